// File: rtl/vector_alu_issue_ctrl_if.sv
// Decode-side and writeback-side handshake bundle for the vector ALU
// issue controller.
//
// Signals:
//   in_valid / in_ready : decode operation handshake
//   in_op               : 5-bit opcode
//   in_src_use          : bit0 rs1, bit1 rs2, bit2 vs1, bit3 vs2 are read
//   in_rs1, in_rs2      : scalar source indices
//   in_vs1, in_vs2      : vector source indices
//   in_rd               : destination index
//   wb_valid / wb_ready : writeback handshake
//   wb_rd, wb_vec, wb_op: completed result destination, file class, opcode
//
// Modports: master = decode + writeback sink, slave = issue controller.
interface vector_alu_issue_ctrl_if #(
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [3:0]       in_src_use;
  logic [REG_W-1:0] in_rs1;
  logic [REG_W-1:0] in_rs2;
  logic [REG_W-1:0] in_vs1;
  logic [REG_W-1:0] in_vs2;
  logic [REG_W-1:0] in_rd;
  logic             wb_valid;
  logic             wb_ready;
  logic [REG_W-1:0] wb_rd;
  logic             wb_vec;
  logic [4:0]       wb_op;

  modport master (
    output in_valid, in_op, in_src_use, in_rs1, in_rs2, in_vs1, in_vs2, in_rd,
    output wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_vec, wb_op
  );

  modport slave (
    input  in_valid, in_op, in_src_use, in_rs1, in_rs2, in_vs1, in_vs2, in_rd,
    input  wb_ready,
    output in_ready, wb_valid, wb_rd, wb_vec, wb_op
  );
endinterface

// File: rtl/vector_alu_issue_ctrl.sv
// Issue and writeback controller for the 4-lane vector ALU.
// Accepts decoded operations, holds back RAW-hazarded ones, drives the ALU
// opcode/enable, tracks in-flight ops through a LAT-deep pipe and presents
// completed results to the register-file writeback port with backpressure.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : decode/writeback handshake bundle (slave side)
//   i_flush     : discard every in-flight operation
//   o_alu_en    : ALU pipeline advance enable
//   o_alu_op    : opcode to ALU on issue, else 0
//   o_illegal   : one-cycle pulse after an opcode >= 19 is consumed
//   o_inflight  : number of valid tracking entries (registered)
module vector_alu_issue_ctrl #(
  parameter int LAT   = 8,
  parameter int REG_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  vector_alu_issue_ctrl_if.slave      bus,
  input  logic                        i_flush,
  output logic                        o_alu_en,
  output logic [4:0]                  o_alu_op,
  output logic                        o_illegal,
  output logic [3:0]                  o_inflight
);

  localparam logic [4:0] OP_LAST_LEGAL = 5'd18;

  // Tracking pipe: index 0 is stage 1, index LAT-1 is the writeback stage.
  logic [LAT-1:0]   r_valid;
  logic [LAT-1:0]   r_vec;
  logic [REG_W-1:0] r_rd [LAT];
  logic [4:0]       r_op [LAT];
  logic             r_illegal;
  logic [3:0]       r_inflight;

  logic             w_stall;
  logic             w_alu_en;
  logic             w_hazard;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_issue;
  logic             w_consume_illegal;
  logic [LAT-1:0]   w_valid_nxt;

  // Scalar-file opcodes: Fadd, Fsub, Fmult, Vdot, Vdota, Vindx, Vreduce.
  function automatic logic f_is_vec(input logic [4:0] op);
    logic v;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9: v = 1'b0;
      default:                                  v = 1'b1;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] f_popcount(input logic [LAT-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < LAT; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  assign w_stall           = r_valid[LAT-1] & ~bus.wb_ready;
  assign w_alu_en          = ~w_stall & ~rst;
  assign w_in_ready        = w_alu_en & ~w_hazard & ~i_flush;
  assign w_accept          = bus.in_valid & w_in_ready;
  assign w_issue           = w_accept & (bus.in_op <= OP_LAST_LEGAL);
  assign w_consume_illegal = w_accept & (bus.in_op > OP_LAST_LEGAL);

  assign bus.in_ready = w_in_ready;
  assign bus.wb_valid = r_valid[LAT-1];
  assign bus.wb_rd    = r_rd[LAT-1];
  assign bus.wb_vec   = r_vec[LAT-1];
  assign bus.wb_op    = r_op[LAT-1];
  assign o_alu_en     = w_alu_en;
  assign o_alu_op     = w_issue ? bus.in_op : 5'd0;
  assign o_illegal    = r_illegal;
  assign o_inflight   = r_inflight;

  // RAW hazard: an enabled source matches a valid entry's rd in the same file.
  // The writeback stage is included, so a consumer waits for the transfer.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (r_valid[i]) begin
        if (r_vec[i]) begin
          if ((bus.in_src_use[2] && (bus.in_vs1 == r_rd[i])) ||
              (bus.in_src_use[3] && (bus.in_vs2 == r_rd[i]))) begin
            w_hazard = 1'b1;
          end else begin
            w_hazard = w_hazard;
          end
        end else begin
          if ((bus.in_src_use[0] && (bus.in_rs1 == r_rd[i])) ||
              (bus.in_src_use[1] && (bus.in_rs2 == r_rd[i]))) begin
            w_hazard = 1'b1;
          end else begin
            w_hazard = w_hazard;
          end
        end
      end else begin
        w_hazard = w_hazard;
      end
    end
  end

  // Next valid vector: flush wins over the shift; a stall holds everything.
  always_comb begin
    w_valid_nxt = r_valid;
    if (rst || i_flush) begin
      w_valid_nxt = '0;
    end else if (w_alu_en) begin
      w_valid_nxt = {r_valid[LAT-2:0], w_issue};
    end else begin
      w_valid_nxt = r_valid;
    end
  end

  // Pipe registers, illegal pulse and registered occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_vec      <= '0;
      r_illegal  <= 1'b0;
      r_inflight <= 4'd0;
      for (int i = 0; i < LAT; i++) begin
        r_rd[i] <= '0;
        r_op[i] <= 5'd0;
      end
    end else begin
      r_valid    <= w_valid_nxt;
      r_illegal  <= w_consume_illegal;
      r_inflight <= f_popcount(w_valid_nxt);
      if (w_alu_en) begin
        // Bubbles carry zeroed payload so idle stages stay clean.
        r_rd[0]  <= w_issue ? bus.in_rd : '0;
        r_op[0]  <= w_issue ? bus.in_op : 5'd0;
        r_vec[0] <= w_issue ? f_is_vec(bus.in_op) : 1'b0;
        for (int i = 1; i < LAT; i++) begin
          r_rd[i]  <= r_rd[i-1];
          r_op[i]  <= r_op[i-1];
          r_vec[i] <= r_vec[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_alu_issue_ctrl.sv
// Self-checking bench for vector_alu_issue_ctrl: directed steps with a
// writeback scoreboard (expected results queued on issue, popped on transfer).
module tb_vector_alu_issue_ctrl;

  typedef struct packed {
    logic [4:0] rd;
    logic       vec;
    logic [4:0] op;
  } wb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       alu_en;
  logic [4:0] alu_op;
  logic       illegal;
  logic [3:0] inflight;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  last_issue_cyc = 0;
  wb_t sb_q[$];
  wb_t mon_e;

  vector_alu_issue_ctrl_if #(.REG_W(5)) bus ();

  vector_alu_issue_ctrl #(.LAT(8), .REG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .i_flush    (flush),
    .o_alu_en   (alu_en),
    .o_alu_op   (alu_op),
    .o_illegal  (illegal),
    .o_inflight (inflight)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic model_vec(input logic [4:0] op);
    return !(op inside {5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every completed transfer must match the oldest issue.
  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
      chk("wb_expected", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, mon_e.rd});
        chk("wb_vec", {31'd0, bus.wb_vec}, {31'd0, mon_e.vec});
        chk("wb_op", {27'd0, bus.wb_op}, {27'd0, mon_e.op});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] su,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [4:0] rd, output int waits);
    wb_t e;
    bit  done;
    bus.in_op = op;
    bus.in_src_use = su;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_vs1 = vs1;
    bus.in_vs2 = vs2;
    bus.in_rd = rd;
    bus.in_valid = 1'b1;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        if (op <= 5'd18) begin
          e.rd = rd;
          e.vec = model_vec(op);
          e.op = op;
          sb_q.push_back(e);
        end
        step();
        last_issue_cyc = cyc;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 40) begin
          chk("issue_timeout", {31'd0, bus.in_ready}, 32'd1);
          done = 1'b1;
        end else begin
          step();
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts negedges from now until wb_valid is seen; also returns inflight at the first.
  task automatic wait_wb(output int lat, output logic [3:0] infl1);
    bit done;
    lat = 0;
    done = 1'b0;
    infl1 = 4'd0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (lat == 1) infl1 = inflight;
      if (bus.wb_valid === 1'b1) begin
        done = 1'b1;
      end else if (lat > 40) begin
        chk("wb_timeout", {31'd0, bus.wb_valid}, 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 80) begin
      step();
      n++;
    end
    chk("drain_empty", sb_q.size(), 32'd0);
    step();
  endtask

  initial begin
    int         w;
    int         lat;
    int         t0;
    logic [3:0] infl1;

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op = 5'd3;
    bus.in_src_use = 4'd0;
    bus.in_rs1 = 5'd0;
    bus.in_rs2 = 5'd0;
    bus.in_vs1 = 5'd0;
    bus.in_vs2 = 5'd0;
    bus.in_rd = 5'd0;
    bus.wb_ready = 1'b1;

    // Reset state
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_inflight", {28'd0, inflight}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;

    // Single Vadd: latency 8, inflight 1 then 0
    issue(5'd3, 4'b1100, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, w);
    wait_wb(lat, infl1);
    chk("vadd_latency", lat, 32'd8);
    chk("vadd_inflight_1", {28'd0, infl1}, 32'd1);
    step();
    @(negedge clk);
    chk("vadd_inflight_0", {28'd0, inflight}, 32'd0);
    step();

    // RAW: Fadd rd=5 then Fmult reading rs1=5
    issue(5'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, w);
    t0 = last_issue_cyc;
    issue(5'd2, 4'b0001, 5'd5, 5'd0, 5'd0, 5'd0, 5'd7, w);
    chk("raw_wait_cycles", w, 32'd8);
    chk("raw_issue_gap", last_issue_cyc - t0, 32'd9);
    wait_wb(lat, infl1);
    chk("raw_consumer_latency", lat, 32'd8);
    step();

    // 8 back-to-back ops, then 3 cycles of writeback backpressure
    for (int i = 0; i < 8; i++) begin
      issue(5'(i + 10), 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'(i + 10), w);
      chk("b2b_no_wait", w, 32'd0);
    end
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    bus.wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_alu_en", {31'd0, alu_en}, 32'd0);
      chk("stall_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("stall_wb_rd", {27'd0, bus.wb_rd}, 32'd12);
      chk("stall_wb_op", {27'd0, bus.wb_op}, 32'd12);
      step();
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_alu_en", {31'd0, alu_en}, 32'd1);
    drain();

    // Scalar rd=4 in flight does not block a vector read of vs1=4
    issue(5'd0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, w);
    issue(5'd10, 4'b0100, 5'd0, 5'd0, 5'd4, 5'd0, 5'd6, w);
    chk("cross_file_no_hazard", w, 32'd0);
    drain();

    // Illegal opcode consumed
    issue(5'd3, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd8, w);
    issue(5'd25, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, w);
    chk("illegal_accepted", w, 32'd0);
    @(negedge clk);
    chk("illegal_pulse", {31'd0, illegal}, 32'd1);
    chk("illegal_inflight", {28'd0, inflight}, 32'd1);
    step();
    @(negedge clk);
    chk("illegal_pulse_end", {31'd0, illegal}, 32'd0);
    chk("illegal_inflight_2", {28'd0, inflight}, 32'd1);
    drain();

    // Flush with 5 ops in flight
    for (int i = 0; i < 5; i++) begin
      issue(5'(i + 3), 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'(i + 20), w);
    end
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = 5'd4;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("flush_inflight_before", {28'd0, inflight}, 32'd5);
    sb_q.delete();
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_inflight_after", {28'd0, inflight}, 32'd0);
    repeat (12) step();

    // Reset with 3 ops in flight
    for (int i = 0; i < 3; i++) begin
      issue(5'(i + 14), 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'(i + 25), w);
    end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = 5'd5;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mid_rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("mid_rst_alu_op", {27'd0, alu_op}, 32'd0);
    sb_q.delete();
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("mid_rst_inflight", {28'd0, inflight}, 32'd0);
    chk("mid_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("mid_rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    chk("mid_rst_wb_vec", {31'd0, bus.wb_vec}, 32'd0);
    chk("mid_rst_wb_op", {27'd0, bus.wb_op}, 32'd0);
    repeat (12) step();

    // Normal operation resumes after reset
    issue(5'd17, 4'b1000, 5'd0, 5'd0, 5'd0, 5'd26, 5'd30, w);
    chk("post_rst_no_hazard", w, 32'd0);
    wait_wb(lat, infl1);
    chk("post_rst_latency", lat, 32'd8);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
